// File: rtl/fifo_burst_writer.sv
// Burst traffic source for the write side of a FIFO under test.
// Issues NUM_BURSTS bursts of BURST_LEN accepted writes and counts writes and back-pressure stalls.
module fifo_burst_writer #(
    parameter int BURST_LEN  = 8,
    parameter int IDLE_LEN   = 4,
    parameter int NUM_BURSTS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             wrdy_i,
    output logic             we_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int BEAT_W  = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
    localparam int GAP_W   = (IDLE_LEN   > 1) ? $clog2(IDLE_LEN)   : 1;
    localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((IDLE_LEN > 0) ? (IDLE_LEN - 1) : 0);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(NUM_BURSTS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_r,     state_nxt_s;
    logic [BEAT_W-1:0]  beat_r,      beat_nxt_s;
    logic [GAP_W-1:0]   gap_r,       gap_nxt_s;
    logic [BURST_W-1:0] burst_r,     burst_nxt_s;
    logic [CNT_W-1:0]   wr_cnt_r,    wr_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r, stall_nxt_s;
    logic               busy_r,      busy_nxt_s;
    logic               done_r,      done_nxt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Write enable follows ready only while bursting, so a full FIFO is never written.
    assign we_o        = (state_r == ST_BURST) && wrdy_i;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign wr_cnt_o    = wr_cnt_r;
    assign stall_cnt_o = stall_cnt_r;

    // Next-state and counter update logic; wrdy_i is only looked at in BURST.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        gap_nxt_s   = gap_r;
        burst_nxt_s = burst_r;
        wr_nxt_s    = wr_cnt_r;
        stall_nxt_s = stall_cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nxt_s = ST_BURST;
                    beat_nxt_s  = {BEAT_W{1'b0}};
                    gap_nxt_s   = {GAP_W{1'b0}};
                    burst_nxt_s = {BURST_W{1'b0}};
                    wr_nxt_s    = {CNT_W{1'b0}};
                    stall_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_BURST: begin
                if (wrdy_i) begin
                    wr_nxt_s = sat_inc(wr_cnt_r);
                    if (beat_r == BEAT_LAST) begin
                        beat_nxt_s  = {BEAT_W{1'b0}};
                        burst_nxt_s = burst_r + BURST_W'(1);
                        if (burst_r == BURST_LAST) begin
                            state_nxt_s = ST_DONE;
                        end else if (IDLE_LEN > 0) begin
                            state_nxt_s = ST_GAP;
                        end else begin
                            state_nxt_s = ST_BURST;
                        end
                    end else begin
                        beat_nxt_s = beat_r + BEAT_W'(1);
                    end
                end else begin
                    stall_nxt_s = sat_inc(stall_cnt_r);
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    gap_nxt_s   = {GAP_W{1'b0}};
                    state_nxt_s = ST_BURST;
                end else begin
                    gap_nxt_s = gap_r + GAP_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_BURST) || (state_nxt_s == ST_GAP);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, counters and status flags; reset aborts a run at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            beat_r      <= {BEAT_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            burst_r     <= {BURST_W{1'b0}};
            wr_cnt_r    <= {CNT_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            beat_r      <= beat_nxt_s;
            gap_r       <= gap_nxt_s;
            burst_r     <= burst_nxt_s;
            wr_cnt_r    <= wr_nxt_s;
            stall_cnt_r <= stall_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: three instances cover default, back-to-back
// single-beat, and narrow saturating-counter configurations.
module tb_fifo_burst_writer;

    logic clk;
    int   n_assert;
    int   n_fail;

    logic rst_na, start_a, wrdy_a, we_a, busy_a, done_a;
    logic [15:0] wr_a, stall_a;
    logic rst_nb, start_b, wrdy_b, we_b, busy_b, done_b;
    logic [15:0] wr_b, stall_b;
    logic rst_nc, start_c, wrdy_c, we_c, busy_c, done_c;
    logic [1:0] wr_c, stall_c;

    fifo_burst_writer dut_a (
        .clk_i(clk), .rst_ni(rst_na), .start_i(start_a), .wrdy_i(wrdy_a),
        .we_o(we_a), .busy_o(busy_a), .done_o(done_a),
        .wr_cnt_o(wr_a), .stall_cnt_o(stall_a)
    );

    fifo_burst_writer #(.BURST_LEN(1), .IDLE_LEN(0), .NUM_BURSTS(5)) dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .start_i(start_b), .wrdy_i(wrdy_b),
        .we_o(we_b), .busy_o(busy_b), .done_o(done_b),
        .wr_cnt_o(wr_b), .stall_cnt_o(stall_b)
    );

    fifo_burst_writer #(.CNT_W(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_nc), .start_i(start_c), .wrdy_i(wrdy_c),
        .we_o(we_c), .busy_o(busy_c), .done_o(done_c),
        .wr_cnt_o(wr_c), .stall_cnt_o(stall_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Default config: 8 writes then 4 idle per burst; a stall window shifts the rest.
    function automatic logic exp_we_a(input int i, input int lo, input int hi);
        int j;
        if (i >= lo && i <= hi) return 1'b0;
        j = (hi >= lo && i > hi) ? i - (hi - lo + 1) : i;
        return ((j % 12) < 8);
    endfunction

    // Runs dut_a from its first busy cycle until busy drops (bounded), dropping wrdy in [lo,hi].
    task automatic run_a(input int lo, input int hi, output int busy_n, output int we_n,
                         output int pat_err);
        busy_n = 0; we_n = 0; pat_err = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_a) break;
            wrdy_a = !(i >= lo && i <= hi);
            #1;
            if (we_a) we_n++;
            if (we_a !== exp_we_a(i, lo, hi)) pat_err++;
            busy_n++;
            @(posedge clk);
            #1;
        end
        wrdy_a = 1'b1;
    endtask

    initial begin
        int bn, wn, pe;
        n_assert = 0; n_fail = 0;
        rst_na = 1'b0; rst_nb = 1'b0; rst_nc = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        wrdy_a = 1'b1; wrdy_b = 1'b1; wrdy_c = 1'b0;
        #7;
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_wr", {16'd0, wr_a}, 32'd0);
        chk("rst_stall", {16'd0, stall_a}, 32'd0);
        step(1);
        rst_na = 1'b1; rst_nb = 1'b1; rst_nc = 1'b1;
        step(2);
        chk("idle_no_we", {31'd0, we_a}, 32'd0);

        // T1: free-running run
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        chk("t1_latency_we", {31'd0, we_a}, 32'd1);
        run_a(-1, -2, bn, wn, pe);
        chk("t1_busy_cycles", bn, 44);
        chk("t1_we_cycles", wn, 32);
        chk("t1_pattern_err", pe, 0);
        chk("t1_done", {31'd0, done_a}, 32'd1);
        chk("t1_wr_cnt", {16'd0, wr_a}, 32'd32);
        chk("t1_stall_cnt", {16'd0, stall_a}, 32'd0);
        step(3);
        chk("t1_done_level", {31'd0, done_a}, 32'd1);
        chk("t1_wr_held", {16'd0, wr_a}, 32'd32);

        // T2: three-cycle stall inside the second burst, restarted from DONE
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        chk("t2_done_dropped", {31'd0, done_a}, 32'd0);
        chk("t2_wr_cleared", {16'd0, wr_a}, 32'd0);
        run_a(15, 17, bn, wn, pe);
        chk("t2_busy_cycles", bn, 47);
        chk("t2_we_cycles", wn, 32);
        chk("t2_pattern_err", pe, 0);
        chk("t2_stall_cnt", {16'd0, stall_a}, 32'd3);
        chk("t2_wr_cnt", {16'd0, wr_a}, 32'd32);

        // T5: start held high through the whole run
        start_a = 1'b1;
        step(1);
        chk("t5_stall_cleared", {16'd0, stall_a}, 32'd0);
        run_a(-1, -2, bn, wn, pe);
        chk("t5_busy_cycles", bn, 44);
        chk("t5_pattern_err", pe, 0);
        chk("t5_done", {31'd0, done_a}, 32'd1);
        chk("t5_wr_cnt", {16'd0, wr_a}, 32'd32);
        step(1);
        chk("t5_restart_busy", {31'd0, busy_a}, 32'd1);
        chk("t5_restart_done", {31'd0, done_a}, 32'd0);
        chk("t5_restart_wr", {16'd0, wr_a}, 32'd0);
        start_a = 1'b0;
        run_a(-1, -2, bn, wn, pe);
        chk("t5_run2_busy", bn, 44);
        chk("t5_run2_wr", {16'd0, wr_a}, 32'd32);

        // T4: asynchronous reset during the first gap
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(9);
        chk("t4_in_gap_busy", {31'd0, busy_a}, 32'd1);
        chk("t4_in_gap_we", {31'd0, we_a}, 32'd0);
        chk("t4_wr_before", {16'd0, wr_a}, 32'd8);
        #1 rst_na = 1'b0;
        #1;
        chk("t4_async_busy", {31'd0, busy_a}, 32'd0);
        chk("t4_async_we", {31'd0, we_a}, 32'd0);
        chk("t4_async_done", {31'd0, done_a}, 32'd0);
        chk("t4_async_wr", {16'd0, wr_a}, 32'd0);
        step(1);
        rst_na = 1'b1;
        wn = 0; bn = 0;
        for (int i = 0; i < 10; i++) begin
            if (we_a) wn++;
            if (busy_a) bn++;
            step(1);
        end
        chk("t4_no_we_after", wn, 0);
        chk("t4_no_busy_after", bn, 0);

        // T3: single-beat back-to-back bursts
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        wn = 0; bn = 0;
        for (int i = 0; i < 50; i++) begin
            if (!busy_b) break;
            if (we_b) wn++;
            bn++;
            step(1);
        end
        chk("t3_busy_cycles", bn, 5);
        chk("t3_we_cycles", wn, 5);
        chk("t3_done", {31'd0, done_b}, 32'd1);
        chk("t3_wr_cnt", {16'd0, wr_b}, 32'd5);

        // T6: narrow counters saturate
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        chk("t6_we_stalled", {31'd0, we_c}, 32'd0);
        step(2);
        chk("t6_stall_2", {30'd0, stall_c}, 32'd2);
        step(8);
        chk("t6_stall_sat", {30'd0, stall_c}, 32'd3);
        chk("t6_wr_zero", {30'd0, wr_c}, 32'd0);
        wrdy_c = 1'b1;
        bn = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_c) break;
            bn++;
            step(1);
        end
        chk("t6_busy_cycles", bn, 44);
        chk("t6_done", {31'd0, done_c}, 32'd1);
        chk("t6_wr_sat", {30'd0, wr_c}, 32'd3);
        chk("t6_stall_held", {30'd0, stall_c}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
